// File: rtl/lockstep_sync_pkg.sv
// Shared types and helpers for the lockstep resynchronisation controller.
package lockstep_sync_pkg;

  // Recovery FSM states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    SYNC_RUN     = 2'd0,
    SYNC_UNLOAD  = 2'd1,
    SYNC_SETBACK = 2'd2,
    SYNC_RELOAD  = 2'd3
  } sync_state_e;

  // The only redundancy levels the voter knows how to handle.
  localparam int unsigned DmrCores = 2;
  localparam int unsigned TmrCores = 3;

  // Saturating increment; counters up to 32 bits wide are handled by
  // zero-extending into this helper and truncating the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/lockstep_voter.sv
// Masked majority voter (TMR) or comparator (DMR) for the redundant cores.
module lockstep_voter
  import lockstep_sync_pkg::*;
#(
  parameter int unsigned NumCores = 3,
  parameter int unsigned OutWidth = 72
) (
  input  logic [NumCores-1:0][OutWidth-1:0] core_out_i,
  input  logic [OutWidth-1:0]               compare_mask_i,
  output logic [OutWidth-1:0]               voted_o,
  output logic [NumCores-1:0]               mismatch_o,
  output logic                              uncorrectable_o
);

  if (NumCores == TmrCores) begin : g_tmr
    logic [OutWidth-1:0] a, b, c;
    assign a = core_out_i[0];
    assign b = core_out_i[1];
    assign c = core_out_i[2];

    // Bitwise 2-of-3 majority; the mask only affects error detection,
    // never the value that is forwarded.
    assign voted_o = (a & b) | (a & c) | (b & c);

    for (genvar i = 0; i < NumCores; i++) begin : g_mm
      assign mismatch_o[i] = |((core_out_i[i] ^ voted_o) & compare_mask_i);
    end

    // No core can be trusted when every pair disagrees somewhere under the mask.
    assign uncorrectable_o = (|((a ^ b) & compare_mask_i)) &
                             (|((a ^ c) & compare_mask_i)) &
                             (|((b ^ c) & compare_mask_i));
  end else begin : g_dmr
    logic diff;
    // With two cores the faulty one cannot be identified: blame both.
    assign diff            = |((core_out_i[0] ^ core_out_i[1]) & compare_mask_i);
    assign voted_o         = core_out_i[0];
    assign mismatch_o      = {NumCores{diff}};
    assign uncorrectable_o = diff;
  end

endmodule

// File: rtl/lockstep_sync_ctrl.sv
// Lockstep resynchronisation controller: voting, per-core mismatch counters
// and the RUN/UNLOAD/SETBACK/RELOAD recovery FSM with a timeout watchdog.
//
// Handshake: unload_done_i and reload_done_i are single-cycle pulses from
// software. unload_done_i is only honoured in UNLOAD, reload_done_i only in
// RELOAD; elsewhere they are ignored. There is no backpressure: a pulse is
// consumed in the cycle it is seen, and a pulse in the same cycle as the
// watchdog expiry wins over the timeout.
module lockstep_sync_ctrl
  import lockstep_sync_pkg::*;
#(
  parameter int unsigned NumCores      = 3,
  parameter int unsigned OutWidth      = 72,
  parameter int unsigned CounterWidth  = 8,
  parameter int unsigned SetbackCycles = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumCores-1:0][OutWidth-1:0]     core_out_i,
  input  logic [OutWidth-1:0]                   compare_mask_i,
  input  logic                                  fetch_en_i,
  input  logic                                  force_resync_i,
  input  logic                                  setback_en_i,
  input  logic                                  unload_done_i,
  input  logic                                  reload_done_i,
  input  logic                                  cnt_clear_i,
  output logic [OutWidth-1:0]                   voted_o,
  output logic [NumCores-1:0]                   mismatch_o,
  output logic                                  uncorrectable_o,
  output logic                                  resync_req_o,
  output logic [NumCores-1:0]                   core_setback_o,
  output logic [1:0]                            state_o,
  output logic [NumCores-1:0][CounterWidth-1:0] mismatch_cnt_o,
  output logic                                  timeout_o
);

  if (!(NumCores == DmrCores || NumCores == TmrCores)) begin : g_bad_cores
    $error("lockstep_sync_ctrl: NumCores must be 2 or 3");
  end

  localparam int unsigned TimerW = $clog2(TimeoutCycles);
  localparam int unsigned SbW    = (SetbackCycles > 1) ? $clog2(SetbackCycles) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);
  localparam logic [SbW-1:0]    SbLast    = SbW'(SetbackCycles - 1);
  localparam logic [31:0]       CntMax    = 32'({CounterWidth{1'b1}});

  sync_state_e state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [SbW-1:0]    sb_cnt_q, sb_cnt_d;
  logic              setback_q;
  logic [NumCores-1:0][CounterWidth-1:0] cnt_q;
  logic any_mm, timer_hit, sb_hit, count_en;

  lockstep_voter #(
    .NumCores (NumCores),
    .OutWidth (OutWidth)
  ) u_voter (
    .core_out_i      (core_out_i),
    .compare_mask_i  (compare_mask_i),
    .voted_o         (voted_o),
    .mismatch_o      (mismatch_o),
    .uncorrectable_o (uncorrectable_o)
  );

  assign any_mm         = |mismatch_o;
  assign timer_hit      = (timer_q == TimerLast);
  assign sb_hit         = (sb_cnt_q == SbLast);
  assign count_en       = (state_q == SYNC_RUN) && fetch_en_i;
  assign resync_req_o   = (state_q != SYNC_RUN) | any_mm | force_resync_i;
  assign core_setback_o = {NumCores{setback_q}};
  assign state_o        = state_q;
  assign mismatch_cnt_o = cnt_q;

  // Next state: fetch disable dominates, then the watchdog, then normal flow.
  always_comb begin
    state_d   = state_q;
    timeout_o = 1'b0;
    if (!fetch_en_i) begin
      state_d = SYNC_RUN;
    end else begin
      case (state_q)
        SYNC_RUN: begin
          if (any_mm || force_resync_i) state_d = SYNC_UNLOAD;
        end
        SYNC_UNLOAD: begin
          if (unload_done_i) begin
            state_d = setback_en_i ? SYNC_SETBACK : SYNC_RELOAD;
          end else if (timer_hit) begin
            state_d   = SYNC_RUN;
            timeout_o = 1'b1;
          end
        end
        SYNC_SETBACK: begin
          if (sb_hit) state_d = SYNC_RELOAD;
        end
        SYNC_RELOAD: begin
          if (reload_done_i) begin
            state_d = SYNC_RUN;
          end else if (timer_hit) begin
            state_d   = SYNC_RUN;
            timeout_o = 1'b1;
          end else if (any_mm && setback_en_i) begin
            state_d = SYNC_SETBACK;
          end
        end
        default: state_d = SYNC_RUN;
      endcase
    end
  end

  // Watchdog and setback-length counters restart on every state change.
  always_comb begin
    timer_d  = '0;
    sb_cnt_d = '0;
    if (state_d == state_q) begin
      if (state_q == SYNC_UNLOAD || state_q == SYNC_RELOAD) timer_d = timer_q + TimerW'(1);
      if (state_q == SYNC_SETBACK) sb_cnt_d = sb_cnt_q + SbW'(1);
    end
  end

  // State, timers and the registered setback drive.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SYNC_RUN;
      timer_q   <= '0;
      sb_cnt_q  <= '0;
      setback_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sb_cnt_q  <= sb_cnt_d;
      setback_q <= (state_d == SYNC_SETBACK);
    end
  end

  // Per-core saturating mismatch counters; clear beats a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NumCores; i++) begin
        if (cnt_clear_i) begin
          cnt_q[i] <= '0;
        end else if (count_en && mismatch_o[i]) begin
          cnt_q[i] <= CounterWidth'(sat_inc(32'(cnt_q[i]), CntMax));
        end
      end
    end
  end

endmodule

// File: tb/tb_lockstep_sync_ctrl.sv
// Bench for lockstep_sync_ctrl: a TMR and a DMR instance share control
// inputs; a behavioural model predicts every output each cycle.
module tb_lockstep_sync_ctrl;
  localparam int W   = 72;
  localparam int CW  = 8;
  localparam int SBC = 4;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0][W-1:0] t_core;
  logic [1:0][W-1:0] d_core;
  logic [W-1:0] mask;
  logic fetch_en, force_rs, sb_en, unload_done, reload_done, cnt_clear;

  logic [W-1:0] t_voted, d_voted;
  logic [2:0] t_mm, t_sb;
  logic [1:0] d_mm, d_sb, t_st, d_st;
  logic t_unc, d_unc, t_rr, d_rr, t_to, d_to;
  logic [2:0][CW-1:0] t_cnt;
  logic [1:0][CW-1:0] d_cnt;

  assign d_core = t_core[1:0];

  lockstep_sync_ctrl #(.NumCores(3), .OutWidth(W), .CounterWidth(CW),
                       .SetbackCycles(SBC), .TimeoutCycles(TO)) u_tmr (
    .clk_i(clk), .rst_ni(rst_n), .core_out_i(t_core), .compare_mask_i(mask),
    .fetch_en_i(fetch_en), .force_resync_i(force_rs), .setback_en_i(sb_en),
    .unload_done_i(unload_done), .reload_done_i(reload_done), .cnt_clear_i(cnt_clear),
    .voted_o(t_voted), .mismatch_o(t_mm), .uncorrectable_o(t_unc), .resync_req_o(t_rr),
    .core_setback_o(t_sb), .state_o(t_st), .mismatch_cnt_o(t_cnt), .timeout_o(t_to));

  lockstep_sync_ctrl #(.NumCores(2), .OutWidth(W), .CounterWidth(CW),
                       .SetbackCycles(SBC), .TimeoutCycles(TO)) u_dmr (
    .clk_i(clk), .rst_ni(rst_n), .core_out_i(d_core), .compare_mask_i(mask),
    .fetch_en_i(fetch_en), .force_resync_i(force_rs), .setback_en_i(sb_en),
    .unload_done_i(unload_done), .reload_done_i(reload_done), .cnt_clear_i(cnt_clear),
    .voted_o(d_voted), .mismatch_o(d_mm), .uncorrectable_o(d_unc), .resync_req_o(d_rr),
    .core_setback_o(d_sb), .state_o(d_st), .mismatch_cnt_o(d_cnt), .timeout_o(d_to));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance (0 = TMR, 1 = DMR): phase number, cycles spent in the
  // current phase, and mismatch counts.
  int m_state[2];
  int m_age[2];
  int m_cnt[2][3];

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic model_vote(input int k, output logic [W-1:0] v,
                            output logic [2:0] mm, output logic unc);
    logic [W-1:0] c[3];
    int ones;
    int pd;
    for (int i = 0; i < 3; i++) c[i] = t_core[i];
    v = '0; mm = '0; unc = 1'b0; pd = 0;
    if (k == 0) begin
      for (int b = 0; b < W; b++) begin
        ones = int'(c[0][b]) + int'(c[1][b]) + int'(c[2][b]);
        v[b] = (ones >= 2);
      end
      for (int i = 0; i < 3; i++)
        for (int b = 0; b < W; b++)
          if (mask[b] && (c[i][b] != v[b])) mm[i] = 1'b1;
      if (((c[0] ^ c[1]) & mask) != '0) pd++;
      if (((c[0] ^ c[2]) & mask) != '0) pd++;
      if (((c[1] ^ c[2]) & mask) != '0) pd++;
      unc = (pd == 3);
    end else begin
      v = c[0];
      if (((c[0] ^ c[1]) & mask) != '0) begin
        mm = 3'b011;
        unc = 1'b1;
      end
    end
  endtask

  // Check every output of both instances against the model, then advance
  // one clock and update the model. Called at a negedge with inputs set.
  task automatic step();
    logic [W-1:0] v, ov;
    logic [2:0] mm, omm, osb, esb;
    logic unc, any, to, ounc, orr, oto;
    logic [1:0] ost;
    int ocnt[3];
    int nxt[2];
    logic [2:0] mm_s[2];
    string p;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_vote(k, v, mm, unc);
      any = |mm;
      to = 1'b0;
      if (!fetch_en) nxt[k] = 0;
      else begin
        case (m_state[k])
          0: nxt[k] = (any || force_rs) ? 1 : 0;
          1: if (unload_done) nxt[k] = sb_en ? 2 : 3;
             else if (m_age[k] >= TO - 1) begin to = 1'b1; nxt[k] = 0; end
             else nxt[k] = 1;
          2: nxt[k] = (m_age[k] >= SBC - 1) ? 3 : 2;
          default: if (reload_done) nxt[k] = 0;
             else if (m_age[k] >= TO - 1) begin to = 1'b1; nxt[k] = 0; end
             else if (any && sb_en) nxt[k] = 2;
             else nxt[k] = 3;
        endcase
      end
      mm_s[k] = mm;
      if (k == 0) begin
        p = "tmr_"; ov = t_voted; omm = t_mm; ounc = t_unc; orr = t_rr; oto = t_to;
        ost = t_st; osb = t_sb;
        for (int i = 0; i < 3; i++) ocnt[i] = int'(t_cnt[i]);
        esb = (m_state[k] == 2) ? 3'b111 : 3'b000;
      end else begin
        p = "dmr_"; ov = d_voted; omm = {1'b0, d_mm}; ounc = d_unc; orr = d_rr; oto = d_to;
        ost = d_st; osb = {1'b0, d_sb};
        ocnt[0] = int'(d_cnt[0]); ocnt[1] = int'(d_cnt[1]); ocnt[2] = 0;
        esb = (m_state[k] == 2) ? 3'b011 : 3'b000;
      end
      check({p, "voted"}, ov, v);
      check({p, "mismatch"}, omm, mm);
      check({p, "uncorrectable"}, ounc, unc);
      check({p, "resync_req"}, orr, (m_state[k] != 0) || any || force_rs);
      check({p, "timeout"}, oto, to);
      check({p, "state"}, ost, m_state[k]);
      check({p, "setback"}, osb, esb);
      for (int i = 0; i < 3; i++) check({p, "cnt"}, ocnt[i], m_cnt[k][i]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3 - k; i++) begin
        if (cnt_clear) m_cnt[k][i] = 0;
        else if (m_state[k] == 0 && fetch_en && mm_s[k][i])
          m_cnt[k][i] = (m_cnt[k][i] >= 255) ? 255 : m_cnt[k][i] + 1;
      end
      m_age[k] = (nxt[k] != m_state[k]) ? 0 : m_age[k] + 1;
      m_state[k] = nxt[k];
    end
    @(negedge clk);
  endtask

  // ---------------- driver helpers ----------------
  logic [W-1:0] base;

  task automatic idle();
    t_core[0] = base; t_core[1] = base; t_core[2] = base;
    mask = '1;
    fetch_en = 1'b1; force_rs = 1'b0; sb_en = 1'b0;
    unload_done = 1'b0; reload_done = 1'b0; cnt_clear = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int sb_len, first_to, to_count, ci, cj;
    logic [W-1:0] m;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_age[k] = 0;
      for (int i = 0; i < 3; i++) m_cnt[k][i] = 0;
    end
    base = rnd();
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    #1;
    check("rst_state", t_st, 0);
    check("rst_setback", t_sb, 0);
    check("rst_cnt", t_cnt, 0);
    check("rst_timeout", t_to, 0);
    step();

    // Single-bit fault on core1 in RUN
    base = rnd(); idle();
    t_core[1][5] = ~t_core[1][5];
    #1;
    check("t1_voted", t_voted, base);
    check("t1_mismatch", t_mm, 3'b010);
    check("t1_dmr_mismatch", d_mm, 2'b11);
    check("t1_dmr_unc", d_unc, 1'b1);
    check("t1_dmr_voted", d_voted, base);
    step();
    idle(); #1;
    check("t1_state", t_st, 1);
    check("t1_cnt0", t_cnt[0], 0);
    check("t1_cnt1", t_cnt[1], 1);
    check("t1_cnt2", t_cnt[2], 0);
    check("t1_dmr_cnt", d_cnt, {8'd1, 8'd1});

    // Unload -> setback for SetbackCycles -> reload -> run
    sb_en = 1'b1; unload_done = 1'b1;
    step();
    unload_done = 1'b0; #1;
    check("t2_state_sb", t_st, 2);
    sb_len = 0;
    for (int n = 0; n < 10 && t_st == 2; n++) begin
      if (t_sb == 3'b111) sb_len++;
      step();
    end
    check("t2_sb_len", sb_len, SBC);
    check("t2_state_rl", t_st, 3);
    check("t2_sb_off", t_sb, 0);
    reload_done = 1'b1;
    step();
    reload_done = 1'b0; #1;
    check("t2_state_run", t_st, 0);
    check("t2_resync_req", t_rr, 1'b0);
    step();

    // Masked-off bit difference is ignored
    m = '1; m[5] = 1'b0; mask = m;
    t_core[2][5] = ~t_core[2][5];
    #1;
    check("t3_mismatch", t_mm, 3'b000);
    step();
    idle(); #1;
    check("t3_state", t_st, 0);
    check("t3_cnt2", t_cnt[2], 0);

    // Watchdog expiry in UNLOAD
    force_rs = 1'b1;
    step();
    force_rs = 1'b0;
    first_to = -1; to_count = 0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (t_to) begin
        if (first_to < 0) first_to = n;
        to_count++;
      end
      step();
      if (t_st == 0) break;
    end
    check("t5_to_cycle", first_to, TO - 1);
    check("t5_to_count", to_count, 1);
    check("t5_state", t_st, 0);

    // Done pulse on the expiry cycle wins
    force_rs = 1'b1;
    step();
    force_rs = 1'b0;
    repeat (TO - 1) step();
    unload_done = 1'b1; #1;
    check("t5_done_wins_to", t_to, 1'b0);
    step();
    unload_done = 1'b0; #1;
    check("t5_done_state", t_st, 3);
    fetch_en = 1'b0;
    step();
    fetch_en = 1'b1;

    // Counter saturation
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    for (int n = 0; n < 260; n++) begin
      t_core[1][5] = ~base[5]; fetch_en = 1'b1;
      step();
      t_core[1][5] = base[5]; fetch_en = 1'b0;
      step();
    end
    fetch_en = 1'b1; #1;
    check("t6_sat_tmr", t_cnt[1], 255);
    check("t6_sat_dmr", d_cnt[0], 255);

    // Clear beats a simultaneous increment
    t_core[1][5] = ~base[5]; cnt_clear = 1'b1;
    step();
    idle(); #1;
    check("t6_clear_wins", t_cnt[1], 0);

    // fetch_en low during SETBACK
    sb_en = 1'b1; unload_done = 1'b1;
    step();
    unload_done = 1'b0;
    step();
    fetch_en = 1'b0;
    step();
    #1;
    check("t6_fetch_state", t_st, 0);
    check("t6_fetch_setback", t_sb, 0);
    fetch_en = 1'b1;

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      base = rnd();
      t_core[0] = base; t_core[1] = base; t_core[2] = base;
      ci = $urandom_range(0, 15);
      if (ci < 3) begin
        cj = $urandom_range(0, W - 1);
        t_core[ci][cj] = ~t_core[ci][cj];
      end else if (ci == 3) begin
        ci = $urandom_range(0, 2);
        cj = (ci + 1 + $urandom_range(0, 1)) % 3;
        t_core[ci] = t_core[ci] ^ rnd();
        t_core[cj] = t_core[cj] ^ rnd();
      end
      mask = ($urandom_range(0, 3) == 0) ? rnd() : '1;
      fetch_en    = ($urandom_range(0, 31) != 0);
      force_rs    = ($urandom_range(0, 15) == 0);
      sb_en       = ($urandom_range(0, 3) != 0);
      unload_done = ($urandom_range(0, 5) == 0);
      reload_done = ($urandom_range(0, 5) == 0);
      cnt_clear   = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lockstep_sync_ctrl.md
Name: lockstep_sync_ctrl

Overview:
- Parametrised N-core lockstep resynchronisation controller; supports dual (DMR) or triple (TMR) redundancy.
- Votes or compares the per-core output bundles under a per-bit compare mask and counts mismatches per core in saturating counters.
- Runs a RUN/UNLOAD/SETBACK/RELOAD recovery FSM with a programmable setback pulse width and a timeout watchdog.
- Sits between the redundant cores and the interconnect; software unload/reload is handshaked through done pulses.

Parameters:
NumCores, 3, number of redundant cores; only 2 or 3 are legal (elaboration error otherwise)
OutWidth, 72, width of each core's voted output bundle
CounterWidth, 8, width of each per-core mismatch counter (saturating)
SetbackCycles, 4, cycles core_setback_o is held high per setback (>=1)
TimeoutCycles, 1024, maximum cycles spent in UNLOAD or RELOAD before abort (>=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
core_out_i  in  NumCores x OutWidth  per-core output bundles
compare_mask_i  in  OutWidth  1 = bit takes part in mismatch detection
fetch_en_i  in  1  0 forces the FSM to RUN
force_resync_i  in  1  software resync request, level-sampled in RUN
setback_en_i  in  1  enables the SETBACK phase
unload_done_i  in  1  software finished state unload (pulse)
reload_done_i  in  1  software finished state reload (pulse)
cnt_clear_i  in  1  clears all mismatch counters
voted_o  out  OutWidth  voted bundle toward the interconnect
mismatch_o  out  NumCores  per-core mismatch flags (combinational)
uncorrectable_o  out  1  no valid majority exists
resync_req_o  out  1  resynchronisation in progress or requested
core_setback_o  out  NumCores  registered setback to the cores
state_o  out  2  current FSM state
mismatch_cnt_o  out  NumCores x CounterWidth  per-core mismatch counts
timeout_o  out  1  one-cycle pulse on UNLOAD or RELOAD abort

Behaviour:
- Reset:
  - state RUN; all counters 0; core_setback_o 0; timeout_o 0; internal timers 0.
  - Combinational outputs follow their inputs.
- Voting (combinational, 0 latency):
  - NumCores=3: voted_o is the bitwise majority. mismatch_o[i]=|((core_out_i[i]^voted_o)&compare_mask_i). uncorrectable_o=1 when all three masked pairs differ.
  - NumCores=2: voted_o=core_out_i[0]. On any masked difference both mismatch_o bits are 1 and uncorrectable_o=1.
- any_mm = |mismatch_o.
- resync_req_o = (state==RUN & (any_mm | force_resync_i)) | state!=RUN.
- FSM encoding: RUN=0, UNLOAD=1, SETBACK=2, RELOAD=3.
  - RUN: any_mm or force_resync_i -> UNLOAD. Mismatch counter i increments (saturating at all-ones) on that cycle iff mismatch_o[i]. Timer cleared.
  - UNLOAD: unload_done_i -> SETBACK if setback_en_i, else RELOAD.
  - SETBACK: core_setback_o all-ones for exactly SetbackCycles cycles, then -> RELOAD.
  - RELOAD: reload_done_i -> RUN. any_mm & setback_en_i & !reload_done_i -> SETBACK (re-setback).
  - Counters increment only in RUN; mismatches in other states are not counted.
- Timeout:
  - Timer counts while in UNLOAD or RELOAD and clears on any state change.
  - At TimeoutCycles-1 without the done pulse: timeout_o=1 for one cycle, next state RUN.
  - Done pulse in the same cycle as the timeout: done wins, no timeout_o.
- Priorities, highest first:
  1. fetch_en_i=0: next state RUN, setback cleared, timer cleared, counters kept.
  2. Timeout.
  3. Normal transitions.
- cnt_clear_i beats a same-cycle increment; counters read 0 next cycle.
- core_setback_o and state_o come from flops; no combinational path from inputs to them.

Decomposition:
- lockstep_sync_pkg holds:
  - state enum sync_state_e (2-bit);
  - localparams for the legal NumCores values;
  - function sat_inc.
- Sub-module lockstep_voter (NumCores, OutWidth) holds the masked voting/compare logic: voted_o, mismatch_o, uncorrectable_o.
- The top holds the FSM, timers and counters.

Test Plan:
- TMR, mask all-ones, core1 bit5 flipped for 1 cycle in RUN -> voted_o = core0 value, mismatch_o=3'b010, state_o goes 0->1, mismatch_cnt_o[1]=1, others 0.
- UNLOAD, setback_en_i=1, unload_done_i pulse -> state_o=2, core_setback_o=3'b111 for exactly 4 cycles, then state_o=3. reload_done_i -> state_o=0, resync_req_o=0.
- Mask bit 5 = 0 with core2 bit5 flipped -> no mismatch_o, state stays RUN, counters unchanged.
- NumCores=2, core1 differs under mask -> mismatch_o=2'b11, uncorrectable_o=1, voted_o=core_out_i[0], both counters increment.
- Stay in UNLOAD with no done, TimeoutCycles=16 -> timeout_o high on cycle 15 only, state_o=0 next. Rerun with unload_done_i on cycle 15 -> no timeout_o.
- Counter at 255 plus mismatch -> stays 255. cnt_clear_i with a simultaneous mismatch -> 0. fetch_en_i=0 during SETBACK -> next cycle state_o=0, core_setback_o=0.
